// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry,
// common to the transmitter and a future receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int UART_FRAME_BITS = 10;
  localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_tx_8n1_if.sv
// Valid/ready word handshake between an upstream producer and the UART transmitter.
interface uart_tx_8n1_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_div_check
      $error("uart_baud_gen: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: accepts a word over valid/ready and shifts it out
// LSB-first between a start and a stop bit on a registered, idle-high line.
module uart_tx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int WIDTH        = 8
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_8n1_if.slave  s_if,
  output logic          tx,
  output logic          busy
);

  generate
    if (WIDTH != UART_DATA_BITS) begin : g_width_check
      $error("uart_tx_8n1: only WIDTH == 8 is supported");
    end
  endgenerate

  uart_state_t      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             bit_end;
  logic             accept;
  logic             restart;

  // Ready also opens on the last stop-bit cycle so frames can abut with no idle gap.
  assign s_if.tx_ready = (state_q == IDLE) || ((state_q == STOP) && bit_end);
  assign accept        = s_if.tx_valid && s_if.tx_ready;
  assign restart       = accept || (state_q == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = 1'b1;

    case (state_q)
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[WIDTH-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      state_d = START;
      shift_d = s_if.tx_data;
      idx_d   = '0;
    end

    // The line is registered from the next state so each bit appears on its own edge.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Self-checking bench for uart_tx_8n1: scoreboarded frame monitor plus per-scenario timing checks.
module tb_uart_tx_8n1;
  import uart_pkg::*;

  localparam int CPB     = 4;
  localparam int CPB_MIN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;
  logic tx_a, busy_a, tx_b, busy_b, tx_c, busy_c;
  logic [7:0] cnt_c;

  int checks = 0;
  int errors = 0;
  logic [7:0] q_a[$];
  bit mon_busy = 1'b0;

  uart_tx_8n1_if #(.WIDTH(8)) ifa ();
  uart_tx_8n1_if #(.WIDTH(8)) ifb ();
  uart_tx_8n1_if #(.WIDTH(8)) ifc ();

  uart_tx_8n1 #(.CLKS_PER_BIT(CPB), .WIDTH(8)) dut_a (
    .clk(clk), .reset(rst_a), .s_if(ifa.slave), .tx(tx_a), .busy(busy_a));
  uart_tx_8n1 #(.CLKS_PER_BIT(CPB_MIN), .WIDTH(8)) dut_b (
    .clk(clk), .reset(rst_b), .s_if(ifb.slave), .tx(tx_b), .busy(busy_b));
  uart_tx_8n1 #(.CLKS_PER_BIT(CPB), .WIDTH(8)) dut_c (
    .clk(clk), .reset(rst_c), .s_if(ifc.slave), .tx(tx_c), .busy(busy_c));

  // Free-running counter feeding dut_c, as in the chip wrapper.
  always_ff @(posedge clk or posedge rst_c) begin
    if (rst_c) cnt_c <= 8'd0;
    else       cnt_c <= cnt_c + 8'd1;
  end
  assign ifc.tx_data  = cnt_c;
  assign ifc.tx_valid = 1'b1;

  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b >= UART_FRAME_BITS - 1) return 1'b1;
    return d[b-1];
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic accept_a(input logic [7:0] d);
    ifa.tx_data  = d;
    ifa.tx_valid = 1'b1;
    q_a.push_back(d);
    @(posedge clk);
    #1;
    ifa.tx_valid = 1'b0;
  endtask

  // Scoreboard monitor for dut_a: samples every cycle of a frame against the model.
  initial begin
    logic [7:0] exp;
    logic [9:0] got, expv;
    int bad;
    bit aborted;
    forever begin
      @(negedge clk);
      if (!rst_a && tx_a === 1'b0) begin
        mon_busy = 1'b1;
        exp = 8'h00;
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected_frame: got a start bit, expected no frame");
        end else begin
          exp = q_a.pop_front();
        end
        for (int b = 0; b < 10; b++) expv[b] = frame_bit(exp, b);
        got = '0; bad = 0; aborted = 1'b0;
        for (int k = 0; k < 10 * CPB; k++) begin
          if (k > 0) @(negedge clk);
          if (rst_a) begin
            aborted = 1'b1;
            break;
          end
          if (k % CPB == CPB / 2) got[k/CPB] = tx_a;
          if (tx_a !== frame_bit(exp, k / CPB)) bad++;
        end
        if (!aborted) begin
          checks++;
          if (got !== expv) begin
            errors++;
            $display("FAIL sb_frame_bits: got %b, expected %b (word %h)", got, expv, exp);
          end
          checks++;
          if (bad != 0) begin
            errors++;
            $display("FAIL sb_frame_timing: got %0d off-model samples, expected 0 (word %h)", bad, exp);
          end
        end else begin
          wait (rst_a == 1'b0);
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic test_reset();
    cyc(2);
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, expected 1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy_a); end
    checks++; if (ifa.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", ifa.tx_ready); end
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    checks++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL reset_release_idle: got tx=%b busy=%b, expected tx=1 busy=0", tx_a, busy_a); end
    checks++; if (tx_b !== 1'b1) begin errors++; $display("FAIL reset_b_tx: got %b, expected 1", tx_b); end
  endtask

  task automatic test_single();
    int nbusy;
    @(posedge clk); #1;
    accept_a(8'hA5);
    nbusy = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy_a === 1'b1) nbusy++;
    end
    checks++; if (nbusy != 10 * CPB) begin errors++; $display("FAIL single_busy_len: got %0d cycles, expected %0d", nbusy, 10 * CPB); end
    checks++; if (tx_a !== 1'b1 || ifa.tx_ready !== 1'b1) begin errors++; $display("FAIL single_idle_after: got tx=%b ready=%b, expected 1 1", tx_a, ifa.tx_ready); end
    checks++; if (q_a.size() != 0 || mon_busy) begin errors++; $display("FAIL single_drain: got %0d pending, expected 0", q_a.size()); end
  endtask

  task automatic test_back_to_back();
    int nready, last;
    @(posedge clk); #1;
    ifa.tx_data  = 8'h00;
    ifa.tx_valid = 1'b1;
    q_a.push_back(8'h00);
    q_a.push_back(8'hFF);
    @(posedge clk); #1;
    ifa.tx_data = 8'hFF;
    nready = 0; last = -1;
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      if (ifa.tx_ready === 1'b1) begin nready++; last = k; end
    end
    @(posedge clk); #1;
    ifa.tx_valid = 1'b0;
    checks++; if (nready != 1 || last != 10 * CPB - 1) begin errors++; $display("FAIL b2b_ready_pulse: got %0d pulses last at %0d, expected 1 at %0d", nready, last, 10 * CPB - 1); end
    @(negedge clk);
    checks++; if (tx_a !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL b2b_no_gap: got tx=%b busy=%b at cycle 40, expected tx=0 busy=1", tx_a, busy_a); end
    cyc(10 * CPB + 4);
    checks++; if (q_a.size() != 0 || mon_busy) begin errors++; $display("FAIL b2b_drain: got %0d pending, expected 0", q_a.size()); end
  endtask

  task automatic test_busy_changes();
    @(posedge clk); #1;
    accept_a(8'h81);
    cyc(4);
    ifa.tx_data = 8'hFF;
    cyc(5);
    ifa.tx_data  = 8'h3C;
    ifa.tx_valid = 1'b1;
    checks++; if (ifa.tx_ready !== 1'b0) begin errors++; $display("FAIL busy_ready_low: got %b, expected 0", ifa.tx_ready); end
    cyc(1);
    ifa.tx_valid = 1'b0;
    cyc(10 * CPB);
    checks++; if (q_a.size() != 0 || mon_busy) begin errors++; $display("FAIL busy_drain: got %0d pending, expected 0", q_a.size()); end
    checks++; if (busy_a !== 1'b0 || tx_a !== 1'b1) begin errors++; $display("FAIL busy_ignored_word: got busy=%b tx=%b, expected 0 1", busy_a, tx_a); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    accept_a(8'h55);
    cyc(12);
    rst_a = 1'b1;
    #1;
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b, expected 1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, expected 0", busy_a); end
    @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    checks++; if (ifa.tx_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b, expected 1", ifa.tx_ready); end
    ifa.tx_data  = 8'h12;
    ifa.tx_valid = 1'b1;
    q_a.push_back(8'h12);
    @(posedge clk); #1;
    ifa.tx_valid = 1'b0;
    cyc(10 * CPB + 4);
    checks++; if (q_a.size() != 0 || mon_busy) begin errors++; $display("FAIL midrst_drain: got %0d pending, expected 0", q_a.size()); end
  endtask

  task automatic test_min_divider();
    @(posedge clk); #1;
    ifb.tx_data  = 8'hC3;
    ifb.tx_valid = 1'b1;
    @(posedge clk); #1;
    ifb.tx_valid = 1'b0;
    for (int k = 0; k < 10 * CPB_MIN; k++) begin
      @(negedge clk);
      checks++;
      if (tx_b !== frame_bit(8'hC3, k / CPB_MIN) || busy_b !== 1'b1) begin
        errors++;
        $display("FAIL min_div_cycle%0d: got tx=%b busy=%b, expected tx=%b busy=1", k, tx_b, busy_b, frame_bit(8'hC3, k / CPB_MIN));
      end
    end
    @(negedge clk);
    checks++; if (busy_b !== 1'b0 || tx_b !== 1'b1) begin errors++; $display("FAIL min_div_end: got busy=%b tx=%b, expected 0 1", busy_b, tx_b); end
  endtask

  task automatic test_integration();
    logic [7:0] got, exp;
    logic stop_bit;
    bit found;
    @(negedge clk);
    rst_c = 1'b0;
    for (int n = 0; n < 4; n++) begin
      found = 1'b0;
      for (int w = 0; w < 100; w++) begin
        @(negedge clk);
        if (tx_c === 1'b0) begin found = 1'b1; break; end
      end
      if (!found) begin
        checks++; errors++;
        $display("FAIL integ_timeout: got no start bit, expected frame %0d", n);
        return;
      end
      got = '0; stop_bit = 1'b0;
      for (int k = 0; k < 10 * CPB; k++) begin
        if (k > 0) @(negedge clk);
        if (k >= CPB && k < 9 * CPB && (k % CPB == CPB / 2)) got[k/CPB - 1] = tx_c;
        if (k == 9 * CPB + CPB / 2) stop_bit = tx_c;
      end
      exp = 8'(n * 10 * CPB);
      checks++; if (got !== exp) begin errors++; $display("FAIL integ_byte%0d: got %h, expected %h", n, got, exp); end
      checks++; if (stop_bit !== 1'b1) begin errors++; $display("FAIL integ_stop%0d: got %b, expected 1", n, stop_bit); end
    end
    rst_c = 1'b1;
  endtask

  initial begin
    ifa.tx_data  = 8'h00;
    ifa.tx_valid = 1'b0;
    ifb.tx_data  = 8'h00;
    ifb.tx_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_changes();
    test_reset_mid();
    test_min_divider();
    test_integration();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
